adc_bcd_conv: RTL and testbench

//  Sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock.

---
 rtl/adc_bcd_conv_pkg.sv | 13 +
 rtl/adc_bcd_conv_add3.sv | 14 +
 rtl/adc_bcd_conv.sv | 113 +++++++++++
 tb/tb_adc_bcd_conv.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/adc_bcd_conv_pkg.sv
// Shared constants and FSM encoding for the ADC-to-BCD converter and the 7-segment display driver.
package adc_bcd_conv_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int DISP_DIGITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/adc_bcd_conv_add3.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 ahead of the shift.
module bcd_add3_digit
  import adc_bcd_conv_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  // A legal digit is at most 9, so the sum stays within 12 and needs no carry out.
  always_comb begin
    digit_o = (digit_i >= BCD_DIGIT_W'(5)) ? digit_i + BCD_DIGIT_W'(3) : digit_i;
  end

endmodule

// File: rtl/adc_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) feeding the display driver.
module adc_bcd_conv
  import adc_bcd_conv_pkg::*;
#(
  parameter int IN_W   = 12,
  parameter int DIGITS = DISP_DIGITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_valid,
  input  logic [IN_W-1:0]               sample_data,
  output logic                          sample_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_data,
  output logic                          bcd_valid,
  output logic                          busy,
  output logic                          overflow
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + IN_W + 1;
  localparam int CNT_W = $clog2(IN_W + 1);

  state_e              state_q, state_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                bcd_valid_q, bcd_valid_d;

  logic [BCD_DIGIT_W-1:0] digit_fix [DIGITS];
  logic [SR_W-1:0]        sr_fix;
  logic [SR_W-1:0]        sr_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3_digit u_add3 (
      .digit_i (sr_q[IN_W + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .digit_o (digit_fix[g])
    );
  end

  // The top bit is sticky: once a carry leaves the top digit the value is >= 10**DIGITS.
  always_comb begin
    sr_fix = sr_q;
    for (int i = 0; i < DIGITS; i++) begin
      sr_fix[IN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W] = digit_fix[i];
    end
    sr_shift = {sr_fix[SR_W-1] | sr_fix[SR_W-2], sr_fix[SR_W-3:0], 1'b0};
  end

  // NOTE: every _d gets a hold default first so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sample_valid && ready_q) begin
          sr_d    = {{(BCD_W + 1){1'b0}}, sample_data};
          cnt_d   = CNT_W'(IN_W - 1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d = sr_shift;
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_DONE: begin
        ovf_d   = sr_q[SR_W-1];
        bcd_d   = sr_q[SR_W-1] ? {DIGITS{4'h9}} : sr_q[IN_W +: BCD_W];
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d     = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    bcd_valid_d = (state_q == ST_DONE);
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      ovf_q       <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      bcd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      ovf_q       <= ovf_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

  assign sample_ready = ready_q;
  assign busy         = busy_q;
  assign bcd_valid    = bcd_valid_q;
  assign bcd_data     = bcd_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_adc_bcd_conv.sv
// Directed scoreboard bench for adc_bcd_conv at IN_W=12 and IN_W=14.
module tb_adc_bcd_conv;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v12, r12, bv12, busy12, o12;
  logic [11:0] d12;
  logic [15:0] b12;
  logic        v14, r14, bv14, busy14, o14;
  logic [13:0] d14;
  logic [15:0] b14;

  adc_bcd_conv #(.IN_W(12), .DIGITS(4)) dut12 (
    .clk (clk), .rst (rst), .sample_valid (v12), .sample_data (d12),
    .sample_ready (r12), .bcd_data (b12), .bcd_valid (bv12), .busy (busy12), .overflow (o12)
  );

  adc_bcd_conv #(.IN_W(14), .DIGITS(4)) dut14 (
    .clk (clk), .rst (rst), .sample_valid (v14), .sample_data (d14),
    .sample_ready (r14), .bcd_data (b14), .bcd_valid (bv14), .busy (busy14), .overflow (o14)
  );

  int cyc = 0;
  int acc12 = 0, acc14 = 0, acc_cyc12 = 0, acc_cyc14 = 0, pul12 = 0, pul14 = 0;
  int errors = 0, checks = 0;
  exp_t q12[$], q14[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && v12 && r12) begin acc12 <= acc12 + 1; acc_cyc12 <= cyc + 1; end
    if (!rst && v14 && r14) begin acc14 <= acc14 + 1; acc_cyc14 <= cyc + 1; end
    if (bv12) pul12 <= pul12 + 1;
    if (bv14) pul14 <= pul14 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: digit extraction by division, clamped to 9999 above range.
  function automatic exp_t model(input int v);
    exp_t e;
    if (v >= 10000) begin
      e.bcd = 16'h9999;
      e.ovf = 1'b1;
    end else begin
      e.bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  function automatic logic        get_bv  (input bit w); return w ? bv14   : bv12;   endfunction
  function automatic logic [15:0] get_bcd (input bit w); return w ? b14    : b12;    endfunction
  function automatic logic        get_ovf (input bit w); return w ? o14    : o12;    endfunction
  function automatic logic        get_rdy (input bit w); return w ? r14    : r12;    endfunction
  function automatic logic        get_busy(input bit w); return w ? busy14 : busy12; endfunction
  function automatic int          get_acc (input bit w); return w ? acc14  : acc12;  endfunction
  function automatic int          get_accc(input bit w); return w ? acc_cyc14 : acc_cyc12; endfunction
  function automatic int          get_pul (input bit w); return w ? pul14  : pul12;  endfunction

  task automatic set_in(input bit w, input logic v, input int d);
    if (w) begin v14 = v; d14 = 14'(d); end
    else   begin v12 = v; d12 = 12'(d); end
  endtask

  task automatic push_drive(input bit w, input int v);
    set_in(w, 1'b1, v);
    if (w) q14.push_back(model(v));
    else   q12.push_back(model(v));
  endtask

  task automatic wait_acc(input bit w, input int base, input string tag, output int acc_c);
    bit got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (get_acc(w) != base) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check({tag, "_accepted"}, 32'(got), 32'd1);
    acc_c = get_accc(w);
  endtask

  task automatic wait_result(input bit w, input string tag, input int acc_c);
    exp_t e;
    bit   got = 1'b0;
    int   pul0 = get_pul(w);
    for (int i = 0; i < 40; i++) begin
      if (get_bv(w)) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check({tag, "_valid_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(cyc - acc_c), w ? 32'd15 : 32'd13);
    if ((w ? q14.size() : q12.size()) == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'(get_bcd(w)) + 32'h10000);
    end else begin
      e = w ? q14.pop_front() : q12.pop_front();
      check({tag, "_bcd"}, 32'(get_bcd(w)), 32'(e.bcd));
      check({tag, "_ovf"}, 32'(get_ovf(w)), 32'(e.ovf));
    end
    @(negedge clk);
    check({tag, "_pulse_once"}, 32'(get_bv(w)), 32'd0);
    check({tag, "_pulse_count"}, 32'(get_pul(w) - pul0), 32'd1);
  endtask

  task automatic convert(input bit w, input int v);
    int a;
    int base = get_acc(w);
    string tag = $sformatf("%s_conv%0d", w ? "w14" : "w12", v);
    push_drive(w, v);
    wait_acc(w, base, tag, a);
    set_in(w, 1'b0, v);
    wait_result(w, tag, a);
  endtask

  initial begin
    int a1, a2, base;
    rst = 1'b1;
    set_in(1'b0, 1'b0, 0);
    set_in(1'b1, 1'b0, 0);

    // Reset held three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bcd",   32'(b12),    32'h0);
    check("rst_valid", 32'(bv12),   32'd0);
    check("rst_busy",  32'(busy12), 32'd0);
    check("rst_ready", 32'(r12),    32'd1);
    check("rst_ovf",   32'(o12),    32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed single conversions at IN_W=12
    convert(1'b0, 0);
    convert(1'b0, 9);
    convert(1'b0, 1234);
    convert(1'b0, 4095);

    // Back-to-back with valid held high
    base = acc12;
    push_drive(1'b0, 100);
    wait_acc(1'b0, base, "b2b_first", a1);
    check("b2b_busy_mid",  32'(busy12), 32'd1);
    check("b2b_ready_mid", 32'(r12),    32'd0);
    push_drive(1'b0, 2500);
    wait_result(1'b0, "b2b_first", a1);
    wait_acc(1'b0, base + 1, "b2b_second", a2);
    set_in(1'b0, 1'b0, 0);
    check("b2b_interval", 32'(a2 - a1), 32'd14);
    wait_result(1'b0, "b2b_second", a2);

    // Data change mid-SHIFT is ignored until ready returns
    base = acc12;
    push_drive(1'b0, 555);
    wait_acc(1'b0, base, "busy_first", a1);
    repeat (5) @(negedge clk);
    push_drive(1'b0, 777);
    wait_result(1'b0, "busy_first", a1);
    wait_acc(1'b0, base + 1, "busy_second", a2);
    set_in(1'b0, 1'b0, 0);
    check("busy_interval", 32'(a2 - a1), 32'd14);
    wait_result(1'b0, "busy_second", a2);

    // Reset mid-conversion after a completed 4095
    convert(1'b0, 4095);
    base = acc12;
    set_in(1'b0, 1'b1, 1000);
    wait_acc(1'b0, base, "midrst", a1);
    set_in(1'b0, 1'b0, 0);
    repeat (5) @(negedge clk);
    check("midrst_busy_before", 32'(busy12), 32'd1);
    base = pul12;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_bcd",   32'(b12),    32'h0);
    check("midrst_valid", 32'(bv12),   32'd0);
    check("midrst_ready", 32'(r12),    32'd1);
    check("midrst_busy",  32'(busy12), 32'd0);
    repeat (20) @(negedge clk);
    check("midrst_no_pulse", 32'(pul12 - base), 32'd0);
    check("midrst_bcd_hold", 32'(b12), 32'h0);

    // Overflow at IN_W=14, then a sweep across the full input range
    convert(1'b1, 12000);
    convert(1'b1, 9999);
    convert(1'b1, 10000);
    convert(1'b1, 9998);
    convert(1'b1, 16383);
    for (int v = 0; v < 16384; v += 53) convert(1'b1, v);
    for (int v = 3; v < 4096; v += 97) convert(1'b0, v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
